mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage_load_align.sv | 27 ++
 rtl/mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the memory stage: opcode/funct3 constants,
// FSM state encoding and the access-alignment helper.
package mem_stage_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Halfwords need an even offset, words need offset zero; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master) and the memory (slave).
interface mem_stage_if;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_bweb;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_bweb,
        input  dm_rdata, dm_ready
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_bweb,
        output dm_rdata, dm_ready
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data extraction: picks the addressed byte/halfword out of the read
// word and sign- or zero-extends it according to funct3.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    // Shift the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted_s = rdata >> {off, 3'b000};
        case (f3)
            F3_B:    data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    data = shifted_s;
            F3_BU:   data = {24'h000000, shifted_s[7:0]};
            F3_HU:   data = {16'h0000, shifted_s[15:0]};
            default: data = shifted_s;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores to data memory, stalls the
// pipeline while memory is busy and registers the writeback bundle.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        M_aluout,
    input  logic [31:0]        M_rs2,
    input  logic [31:0]        M_csr,
    input  logic [4:0]         M_op,
    input  logic [2:0]         M_f3,
    input  logic [4:0]         M_rd,
    input  logic               M_use_rd,
    mem_stage_if.master        dm,
    output logic [31:0]        W_wbdata,
    output logic [4:0]         W_rd,
    output logic               W_use_rd,
    output logic               W_valid,
    output logic               mem_stall,
    output logic               misalign
);

    state_e      state_q, state_d;
    logic        is_load_s, is_store_s, is_csr_s, mis_s, access_s, complete_s;
    logic [1:0]  off_s;
    logic [3:0]  st_bweb_s;
    logic [31:0] st_wdata_s, load_data_s;
    logic        iss_we_s;
    logic [31:0] iss_addr_s, iss_wdata_s;
    logic [3:0]  iss_bweb_s;
    logic        hold_we_q;
    logic [31:0] hold_addr_q, hold_wdata_q;
    logic [3:0]  hold_bweb_q;
    logic [31:0] W_wbdata_q, W_wbdata_d;
    logic [4:0]  W_rd_q, W_rd_d;
    logic        W_use_rd_q, W_use_rd_d, W_valid_q, W_valid_d;

    // Instruction decode and store lane formatting.
    always_comb begin
        is_load_s  = (M_op == OP_LOAD);
        is_store_s = (M_op == OP_STORE);
        is_csr_s   = (M_op == OP_SYSTEM) && (M_f3 != 3'b000);
        off_s      = M_aluout[1:0];
        mis_s      = (is_load_s || is_store_s) && is_misaligned(M_f3, off_s);
        access_s   = (is_load_s || is_store_s) && !mis_s;
        case (M_f3)
            F3_B: begin
                st_bweb_s  = 4'b0001 << off_s;
                st_wdata_s = {4{M_rs2[7:0]}};
            end
            F3_H: begin
                st_bweb_s  = 4'b0011 << off_s;
                st_wdata_s = {2{M_rs2[15:0]}};
            end
            F3_W: begin
                st_bweb_s  = 4'b1111;
                st_wdata_s = M_rs2;
            end
            default: begin
                st_bweb_s  = 4'b0000;
                st_wdata_s = M_rs2;
            end
        endcase
        iss_addr_s = {M_aluout[31:2], 2'b00};
        if (is_store_s) begin
            iss_we_s    = 1'b1;
            iss_bweb_s  = st_bweb_s;
            iss_wdata_s = st_wdata_s;
        end else begin
            iss_we_s    = 1'b0;
            iss_bweb_s  = 4'b0000;
            iss_wdata_s = 32'h0000_0000;
        end
    end

    load_align u_load_align (
        .rdata (dm.dm_rdata),
        .off   (off_s),
        .f3    (M_f3),
        .data  (load_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (access_s && !dm.dm_ready) state_d = ST_WAIT;
                else                          state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (dm.dm_ready) state_d = ST_IDLE;
                else             state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields captured at issue so the bus stays frozen while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_we_q    <= 1'b0;
            hold_addr_q  <= 32'h0000_0000;
            hold_wdata_q <= 32'h0000_0000;
            hold_bweb_q  <= 4'b0000;
        end else if (state_q == ST_IDLE) begin
            hold_we_q    <= iss_we_s;
            hold_addr_q  <= iss_addr_s;
            hold_wdata_q <= iss_wdata_s;
            hold_bweb_q  <= iss_bweb_s;
        end else begin
            hold_we_q    <= hold_we_q;
            hold_addr_q  <= hold_addr_q;
            hold_wdata_q <= hold_wdata_q;
            hold_bweb_q  <= hold_bweb_q;
        end
    end

    // FSM outputs; reset forces the bus and status quiet combinationally.
    always_comb begin
        dm.dm_req   = 1'b0;
        dm.dm_we    = 1'b0;
        dm.dm_addr  = iss_addr_s;
        dm.dm_wdata = 32'h0000_0000;
        dm.dm_bweb  = 4'b0000;
        mem_stall   = 1'b0;
        misalign    = 1'b0;
        complete_s  = 1'b0;
        if (rst) begin
            complete_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dm.dm_req   = access_s;
                    dm.dm_we    = access_s && iss_we_s;
                    dm.dm_wdata = access_s ? iss_wdata_s : 32'h0000_0000;
                    dm.dm_bweb  = access_s ? iss_bweb_s : 4'b0000;
                    mem_stall   = access_s && !dm.dm_ready;
                    misalign    = mis_s;
                    complete_s  = !(access_s && !dm.dm_ready);
                end
                ST_WAIT: begin
                    dm.dm_req   = 1'b1;
                    dm.dm_we    = hold_we_q;
                    dm.dm_addr  = hold_addr_q;
                    dm.dm_wdata = hold_wdata_q;
                    dm.dm_bweb  = hold_bweb_q;
                    mem_stall   = !dm.dm_ready;
                    complete_s  = dm.dm_ready;
                end
                default: complete_s = 1'b0;
            endcase
        end
    end

    // Writeback bundle: a retiring instruction on completion, a bubble otherwise.
    always_comb begin
        W_valid_d  = complete_s;
        W_use_rd_d = complete_s && M_use_rd && !is_store_s && !mis_s;
        W_rd_d     = M_rd;
        if (!complete_s)     W_wbdata_d = W_wbdata_q;
        else if (is_load_s)  W_wbdata_d = load_data_s;
        else if (is_csr_s)   W_wbdata_d = M_csr;
        else                 W_wbdata_d = M_aluout;
    end

    // Writeback pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            W_wbdata_q <= 32'h0000_0000;
            W_rd_q     <= 5'd0;
            W_use_rd_q <= 1'b0;
            W_valid_q  <= 1'b0;
        end else begin
            W_wbdata_q <= W_wbdata_d;
            W_rd_q     <= W_rd_d;
            W_use_rd_q <= W_use_rd_d;
            W_valid_q  <= W_valid_d;
        end
    end

    assign W_wbdata = W_wbdata_q;
    assign W_rd     = W_rd_q;
    assign W_use_rd = W_use_rd_q;
    assign W_valid  = W_valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random
// instructions compared against an arithmetic reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] M_aluout, M_rs2, M_csr;
    logic [4:0]  M_op, M_rd;
    logic [2:0]  M_f3;
    logic        M_use_rd;
    logic [31:0] W_wbdata;
    logic [4:0]  W_rd;
    logic        W_use_rd, W_valid, mem_stall, misalign;
    int          tests = 0;
    int          fails = 0;

    mem_stage_if dm_if ();

    mem_stage dut (
        .clk      (clk),
        .rst      (rst),
        .M_aluout (M_aluout),
        .M_rs2    (M_rs2),
        .M_csr    (M_csr),
        .M_op     (M_op),
        .M_f3     (M_f3),
        .M_rd     (M_rd),
        .M_use_rd (M_use_rd),
        .dm       (dm_if),
        .W_wbdata (W_wbdata),
        .W_rd     (W_rd),
        .W_use_rd (W_use_rd),
        .W_valid  (W_valid),
        .mem_stall(mem_stall),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one instruction; memory answers after lat wait cycles.
    task automatic do_instr(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] rs2, input logic [31:0] csr, input logic [4:0] rd,
                            input logic use_rd, input int lat, input logic [31:0] rdata);
        bit          is_ld, is_st, is_csr, mis, req, exp_use;
        int unsigned sz, off, l;
        logic [31:0] w, part, exp_wb, exp_wdata;
        logic [3:0]  exp_bweb;
        is_ld  = (op == 5'b00000);
        is_st  = (op == 5'b01000);
        is_csr = (op == 5'b11100) && (f3 != 3'b000);
        sz     = 1 << f3[1:0];
        off    = alu % 4;
        mis    = (is_ld || is_st) && ((alu % sz) != 0);
        req    = (is_ld || is_st) && !mis;
        l      = req ? lat : 0;
        exp_bweb  = is_st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
        exp_wdata = (sz == 1) ? (rs2 % 256) * 32'h01010101 :
                    (sz == 2) ? (rs2 % 65536) * 32'h00010001 : rs2;
        w = rdata >> (8 * off);
        if (is_ld) begin
            case (f3)
                3'b000: begin part = w % 256;   exp_wb = (part >= 128)   ? part + 32'hFFFFFF00 : part; end
                3'b001: begin part = w % 65536; exp_wb = (part >= 32768) ? part + 32'hFFFF0000 : part; end
                3'b100: exp_wb = w % 256;
                3'b101: exp_wb = w % 65536;
                default: exp_wb = rdata;
            endcase
        end else begin
            exp_wb = is_csr ? csr : alu;
        end
        exp_use = use_rd && !is_st && !mis;

        @(negedge clk);
        M_op = op; M_f3 = f3; M_aluout = alu; M_rs2 = rs2; M_csr = csr;
        M_rd = rd; M_use_rd = use_rd;
        dm_if.dm_rdata = rdata;
        dm_if.dm_ready = (l == 0);
        for (int c = 0; c <= int'(l); c++) begin
            if (c > 0) begin
                @(negedge clk);
                dm_if.dm_ready = (c == int'(l));
            end
            #1;
            chk("dm_req", dm_if.dm_req, req);
            chk("mem_stall", mem_stall, req && (c < int'(l)));
            chk("misalign", misalign, mis && (c == 0));
            if (req) begin
                chk("dm_addr", dm_if.dm_addr, alu - off);
                chk("dm_we", dm_if.dm_we, is_st);
                chk("dm_bweb", dm_if.dm_bweb, exp_bweb);
                if (is_st) chk("dm_wdata", dm_if.dm_wdata, exp_wdata);
            end
            @(posedge clk);
            #1;
            if (c < int'(l)) begin
                chk("bubble_valid", W_valid, 1'b0);
                chk("bubble_use_rd", W_use_rd, 1'b0);
            end
        end
        chk("W_valid", W_valid, 1'b1);
        chk("W_rd", W_rd, rd);
        chk("W_use_rd", W_use_rd, exp_use);
        if (!is_st && !mis) chk("W_wbdata", W_wbdata, exp_wb);
    endtask

    initial begin
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int         kind;
        logic [4:0] op;
        logic [2:0] f3;

        rst = 1'b1;
        M_op = 5'b01100; M_f3 = 3'b000; M_aluout = 32'h0; M_rs2 = 32'h0; M_csr = 32'h0;
        M_rd = 5'd0; M_use_rd = 1'b0;
        dm_if.dm_rdata = 32'h0; dm_if.dm_ready = 1'b0;
        #1;
        chk("rst_W_wbdata", W_wbdata, 32'h0);
        chk("rst_W_valid", W_valid, 1'b0);
        chk("rst_W_use_rd", W_use_rd, 1'b0);
        chk("rst_dm_req", dm_if.dm_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // LW aligned, same-cycle ready
        do_instr(5'b00000, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1, 1'b1, 0, 32'hDEADBEEF);
        chk("lw_value", W_wbdata, 32'hDEADBEEF);
        // LB at byte 3 with three wait cycles
        do_instr(5'b00000, 3'b000, 32'h103, 32'h0, 32'h0, 5'd2, 1'b1, 3, 32'h80FFFF00);
        chk("lb_sext", W_wbdata, 32'hFFFFFF80);
        // SH to upper half
        do_instr(5'b01000, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 5'd3, 1'b1, 0, 32'h0);
        // Misaligned LW
        do_instr(5'b00000, 3'b010, 32'h101, 32'h0, 32'h0, 5'd4, 1'b1, 2, 32'h0);
        // CSR read then ALU, back to back
        do_instr(5'b11100, 3'b010, 32'h0, 32'h0, 32'h42, 5'd5, 1'b1, 0, 32'h0);
        chk("csr_value", W_wbdata, 32'h42);
        do_instr(5'b01100, 3'b000, 32'h7, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h0);
        chk("alu_value", W_wbdata, 32'h7);

        // Reset while an SW is waiting
        @(negedge clk);
        M_op = 5'b01000; M_f3 = 3'b010; M_aluout = 32'h300; M_rs2 = 32'hCAFEF00D;
        M_rd = 5'd7; M_use_rd = 1'b0; dm_if.dm_ready = 1'b0;
        #1;
        chk("sw_req", dm_if.dm_req, 1'b1);
        chk("sw_stall", mem_stall, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_dm_req", dm_if.dm_req, 1'b0);
        chk("rstw_stall", mem_stall, 1'b0);
        chk("rstw_misalign", misalign, 1'b0);
        chk("rstw_W_valid", W_valid, 1'b0);
        chk("rstw_W_use_rd", W_use_rd, 1'b0);
        chk("rstw_W_rd", W_rd, 5'd0);
        chk("rstw_W_wbdata", W_wbdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        M_op = 5'b01100; M_f3 = 3'b000; M_aluout = 32'h55; M_rd = 5'd8; M_use_rd = 1'b1;
        #1;
        chk("post_rst_req", dm_if.dm_req, 1'b0);
        chk("post_rst_stall", mem_stall, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_valid", W_valid, 1'b1);
        chk("post_rst_wb", W_wbdata, 32'h55);

        // Random instruction mix
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin op = 5'b00000; f3 = ld_f3[$urandom_range(0, 4)]; end
                1: begin op = 5'b01000; f3 = 3'($urandom_range(0, 2)); end
                2: begin op = 5'b11100; f3 = 3'($urandom_range(1, 7)); end
                default: begin op = 5'b01100; f3 = 3'($urandom_range(0, 7)); end
            endcase
            do_instr(op, f3, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
